// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: Moore serial pattern generator.
// Loads a W-bit pattern, shifts it out MSB-first on x_out and repeats it
// 'reps' times, then pulses done for one cycle.
// Optional macro SEQ_PATTERN_TX_GAP_EN inserts one idle (GAP) cycle between
// consecutive repetitions; without it repetitions run back-to-back.
// All outputs are decoded from registered state only.
module seq_pattern_tx #(
   parameter int             W       = 4,
   parameter logic [W-1:0]   PATTERN = 4'b1010,
   parameter int             CNT_W   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_pat,
   input  logic [W-1:0]     pat_in,
   input  logic             start,
   input  logic [CNT_W-1:0] reps,
   output logic             x_out,
   output logic             x_valid,
   output logic             busy,
   output logic             done
);

   localparam int IW = (W > 2) ? $clog2(W) : 1;
   localparam logic [IW-1:0] IDX_MAX = IW'(W - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef SEQ_PATTERN_TX_GAP_EN
   localparam logic [1:0] S_GAP   = 2'd2;
`endif
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       state;
   logic [W-1:0]     pat_reg;
   logic [W-1:0]     shreg;
   logic [IW-1:0]    bit_idx;
   logic [CNT_W-1:0] reps_left;

   // FSM, pattern register, shifter and repetition counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         pat_reg   <= PATTERN;
         shreg     <= '0;
         bit_idx   <= '0;
         reps_left <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (load_pat)
                  pat_reg <= pat_in;
               // reps==0 is a no-op request: no transmission, no done pulse
               if (start && (reps != '0)) begin
                  shreg     <= load_pat ? pat_in : pat_reg;
                  reps_left <= reps;
                  bit_idx   <= IDX_MAX;
                  state     <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (bit_idx == '0) begin
                  if (reps_left > CNT_W'(1)) begin
                     reps_left <= reps_left - CNT_W'(1);
`ifdef SEQ_PATTERN_TX_GAP_EN
                     // reload happens on the way out of GAP
                     shreg <= '0;
                     state <= S_GAP;
`else
                     // back-to-back: next repetition starts on the very next cycle
                     shreg   <= pat_reg;
                     bit_idx <= IDX_MAX;
`endif
                  end else begin
                     reps_left <= '0;
                     shreg     <= '0;
                     state     <= S_DONE;
                  end
               end else begin
                  shreg   <= {shreg[W-2:0], 1'b0};
                  bit_idx <= bit_idx - IW'(1);
               end
            end
`ifdef SEQ_PATTERN_TX_GAP_EN
            S_GAP: begin
               shreg   <= pat_reg;
               bit_idx <= IDX_MAX;
               state   <= S_SHIFT;
            end
`endif
            S_DONE: begin
               // start seen here is deliberately dropped
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Moore output decode from the state register
   always_comb begin
      x_valid = (state == S_SHIFT);
      x_out   = (state == S_SHIFT) & shreg[W-1];
`ifdef SEQ_PATTERN_TX_GAP_EN
      busy    = (state == S_SHIFT) | (state == S_GAP);
`else
      busy    = (state == S_SHIFT);
`endif
      done    = (state == S_DONE);
   end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed self-checking bench for seq_pattern_tx (W=4, PATTERN=1010).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_seq_pattern_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load_pat = 1'b0;
   logic [3:0] pat_in = 4'b0000;
   logic       start = 1'b0;
   logic [3:0] reps = 4'b0000;
   logic       x_out, x_valid, busy, done;

   int checks = 0;
   int errors = 0;

   // results of the last capture window
   logic [63:0] str;
   logic [63:0] vmask;
   int          nv, nd, nb, done_cyc, hits;

   seq_pattern_tx #(.W(4), .PATTERN(4'b1010), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .load_pat(load_pat), .pat_in(pat_in),
      .start(start), .reps(reps), .x_out(x_out), .x_valid(x_valid),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // one-cycle start pulse; returns just after the edge that samples it
   task automatic pulse_start(input logic [3:0] r, input logic ld, input logic [3:0] p);
      start = 1'b1; reps = r; load_pat = ld; pat_in = p;
      @(posedge clk); #1;
      start = 1'b0; load_pat = 1'b0;
   endtask

   // record n cycles of output; index i is cycle i+1 after the start edge
   task automatic capture(input int n);
      logic [3:0] win;
      str = '0; vmask = '0; win = '0;
      nv = 0; nd = 0; nb = 0; done_cyc = 0; hits = 0;
      for (int i = 0; i < n; i++) begin
         if (x_valid) begin
            str = {str[62:0], x_out};
            win = {win[2:0], x_out};
            nv++;
            vmask[i] = 1'b1;
            // overlapping 1010 detector
            if (nv >= 4 && win == 4'b1010) hits++;
         end
         if (busy) nb++;
         if (done) begin
            nd++;
            if (done_cyc == 0) done_cyc = i + 1;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if ({x_out, x_valid, busy, done} !== 4'b0000) begin
         errors++; $display("FAIL reset_outputs: got %b want 0000", {x_out, x_valid, busy, done});
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({x_out, x_valid, busy, done} !== 4'b0000) begin
         errors++; $display("FAIL idle_after_reset: got %b want 0000", {x_out, x_valid, busy, done});
      end
   endtask

   task automatic test_single;
      pulse_start(4'd1, 1'b0, 4'b0000);
      capture(8);
      checks++;
      if (nv != 4 || str[3:0] !== 4'b1010) begin
         errors++; $display("FAIL single_stream: got %0d bits %b want 4 bits 1010", nv, str[3:0]);
      end
      checks++;
      if (nd != 1 || done_cyc != 5) begin
         errors++; $display("FAIL single_done: got %0d pulses at %0d want 1 at 5", nd, done_cyc);
      end
      checks++;
      if (nb != 4 || busy !== 1'b0) begin
         errors++; $display("FAIL single_busy: got %0d busy cycles, busy=%b want 4, 0", nb, busy);
      end
   endtask

   task automatic test_reps3;
      pulse_start(4'd3, 1'b0, 4'b0000);
      capture(16);
      checks++;
      if (nv != 12 || str[11:0] !== 12'b101010101010) begin
         errors++; $display("FAIL reps3_stream: got %0d bits %b want 12 bits 101010101010", nv, str[11:0]);
      end
      checks++;
      if (hits != 5) begin
         errors++; $display("FAIL reps3_detect: got %0d hits want 5", hits);
      end
      checks++;
      if (nd != 1 || done_cyc != 13) begin
         errors++; $display("FAIL reps3_done: got %0d pulses at %0d want 1 at 13", nd, done_cyc);
      end
   endtask

   task automatic test_reps0;
      pulse_start(4'd0, 1'b0, 4'b0000);
      capture(8);
      checks++;
      if (nv != 0 || nd != 0 || nb != 0) begin
         errors++; $display("FAIL reps0_ignored: got valid=%0d done=%0d busy=%0d want 0 0 0", nv, nd, nb);
      end
   endtask

   task automatic test_abuse_midtx;
      logic [7:0] s;
      int v, d, dc;
      s = '0; v = 0; d = 0; dc = 0;
      pulse_start(4'd2, 1'b0, 4'b0000);
      for (int i = 0; i < 12; i++) begin
         if (x_valid) begin s = {s[6:0], x_out}; v++; end
         if (done) begin d++; if (dc == 0) dc = i + 1; end
         // hammer start/load in cycle 2 and at the repetition boundary (cycle 4)
         if (i == 1 || i == 3) begin
            start = 1'b1; load_pat = 1'b1; pat_in = 4'b0000; reps = 4'd5;
         end else begin
            start = 1'b0; load_pat = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0; load_pat = 1'b0;
      checks++;
      if (v != 8 || s !== 8'b10101010) begin
         errors++; $display("FAIL abuse_stream: got %0d bits %b want 8 bits 10101010", v, s);
      end
      checks++;
      if (d != 1 || dc != 9) begin
         errors++; $display("FAIL abuse_done: got %0d pulses at %0d want 1 at 9", d, dc);
      end
      pulse_start(4'd1, 1'b0, 4'b0000);
      capture(6);
      checks++;
      if (nv != 4 || str[3:0] !== 4'b1010) begin
         errors++; $display("FAIL abuse_patreg: got %0d bits %b want 4 bits 1010", nv, str[3:0]);
      end
   endtask

   task automatic test_start_in_done;
      int v;
      v = 0;
      pulse_start(4'd1, 1'b0, 4'b0000);
      repeat (4) begin @(posedge clk); #1; end
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL done_cycle5: got %b want 1", done);
      end
      start = 1'b1; reps = 4'd1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (x_valid || busy) v++;
         @(posedge clk); #1;
      end
      checks++;
      if (v != 0) begin
         errors++; $display("FAIL start_in_done: got %0d active cycles want 0", v);
      end
   endtask

   task automatic test_load;
      load_pat = 1'b1; pat_in = 4'b1100;
      @(posedge clk); #1;
      load_pat = 1'b0; pat_in = 4'b0000;
      pulse_start(4'd2, 1'b0, 4'b0000);
      capture(12);
      checks++;
      if (nv != 8 || str[7:0] !== 8'b11001100) begin
         errors++; $display("FAIL load_stream: got %0d bits %b want 8 bits 11001100", nv, str[7:0]);
      end
      checks++;
      if (nd != 1 || done_cyc != 9) begin
         errors++; $display("FAIL load_done: got %0d pulses at %0d want 1 at 9", nd, done_cyc);
      end
      pulse_start(4'd1, 1'b1, 4'b0110);
      capture(8);
      checks++;
      if (nv != 4 || str[3:0] !== 4'b0110) begin
         errors++; $display("FAIL load_with_start: got %0d bits %b want 4 bits 0110", nv, str[3:0]);
      end
      pulse_start(4'd1, 1'b0, 4'b1111);
      capture(8);
      checks++;
      if (nv != 4 || str[3:0] !== 4'b0110) begin
         errors++; $display("FAIL load_retained: got %0d bits %b want 4 bits 0110", nv, str[3:0]);
      end
   endtask

   task automatic test_reset_mid;
      // pat_reg holds 0110 here; cycle 3 carries the third bit (1)
      pulse_start(4'd2, 1'b0, 4'b0000);
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if ({x_valid, x_out} !== 2'b11) begin
         errors++; $display("FAIL midreset_pre: got %b want 11", {x_valid, x_out});
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({x_out, x_valid, busy, done} !== 4'b0000) begin
         errors++; $display("FAIL midreset_async: got %b want 0000", {x_out, x_valid, busy, done});
      end
      @(posedge clk); #1;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      pulse_start(4'd1, 1'b0, 4'b0000);
      capture(6);
      checks++;
      if (nv != 4 || str[3:0] !== 4'b1010 || nd != 1) begin
         errors++; $display("FAIL midreset_after: got %0d bits %b done=%0d want 4 bits 1010 done=1", nv, str[3:0], nd);
      end
   endtask

`ifdef SEQ_PATTERN_TX_GAP_EN
   task automatic test_gap;
      pulse_start(4'd2, 1'b0, 4'b0000);
      capture(12);
      checks++;
      if (vmask[9:0] !== 10'b0111101111 || str[7:0] !== 8'b10101010) begin
         errors++; $display("FAIL gap_stream: got mask %b bits %b want 0111101111 10101010", vmask[9:0], str[7:0]);
      end
      checks++;
      if (nd != 1 || done_cyc != 10 || nb != 9) begin
         errors++; $display("FAIL gap_done: got %0d pulses at %0d busy=%0d want 1 at 10 busy=9", nd, done_cyc, nb);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_single;
      test_reps3;
      test_reps0;
      test_abuse_midtx;
      test_start_in_done;
      test_load;
      test_reset_mid;
`ifdef SEQ_PATTERN_TX_GAP_EN
      test_gap;
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
